light_monitor: RTL

LIGHT_MONITOR -- requirements
Module: light_monitor

---
 rtl/light_monitor_pkg.sv | 43 ++++
 rtl/light_monitor_blink_gen.sv | 46 ++++
 rtl/light_monitor.sv | 132 +++++++++++++
 3 files changed

// File: rtl/light_monitor_pkg.sv
// Shared light encoding, fault codes and monitor state for the intersection
// controller and its safety monitor.
package light_monitor_pkg;

  localparam int LIGHT_W = 3;
  typedef logic [LIGHT_W-1:0] light_t;

  // One-hot {red,yellow,green}; any other pattern is illegal
  localparam light_t LIGHT_RED = 3'b100;
  localparam light_t LIGHT_YEL = 3'b010;
  localparam light_t LIGHT_GRN = 3'b001;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_CONFLICT = 2'b01,
    FC_ILLEGAL  = 2'b10,
    FC_SKIP_YEL = 2'b11
  } fault_code_e;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FAULT  = 1'b1
  } mon_state_e;

  typedef struct packed {
    logic illegal;
    logic conflict;
    logic skip_yel;
  } fault_flags_t;

  function automatic logic light_legal(light_t l);
    return (l == LIGHT_RED) || (l == LIGHT_YEL) || (l == LIGHT_GRN);
  endfunction

  // Several causes in one cycle collapse to the most severe
  function automatic fault_code_e fault_prio(fault_flags_t f);
    if (f.illegal)  return FC_ILLEGAL;
    if (f.conflict) return FC_CONFLICT;
    if (f.skip_yel) return FC_SKIP_YEL;
    return FC_NONE;
  endfunction

endpackage

// File: rtl/light_monitor_blink_gen.sv
// Half-period flasher: output starts on after clear and toggles every HALF
// enabled cycles.
module blink_gen #(
  parameter int HALF = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic on_o
);

  localparam int BW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [BW-1:0] cnt_q, cnt_d;
  logic          on_q, on_d;

  always_comb begin
    cnt_d = cnt_q;
    on_d  = on_q;
    if (clr_i) begin
      cnt_d = '0;
      on_d  = 1'b1;
    end else if (en_i) begin
      if (cnt_q == BW'(HALF - 1)) begin
        cnt_d = '0;
        on_d  = ~on_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      on_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      on_q  <= on_d;
    end
  end

  assign on_o = on_q;

endmodule

// File: rtl/light_monitor.sv
// Safety monitor between the light sequencer and the lamp drivers: passes the
// lights through, latches conflict/illegal/skipped-yellow faults and flashes red.
module light_monitor
  import light_monitor_pkg::*;
#(
  parameter int CONFLICT_CYCLES = 2,
  parameter int BLINK_HALF      = 5
) (
  input  logic       iClk,
  input  logic       iRstN,
  input  logic [2:0] main_st,
  input  logic [2:0] cross_st,
  input  logic       iFaultClr,
  output logic [2:0] oMainLamp,
  output logic [2:0] oCrossLamp,
  output logic       oFault,
  output logic [1:0] oFaultCode
);

  localparam int NUM_APP = 2;  // index 0 = main road, 1 = cross road
  localparam int CW      = $clog2(CONFLICT_CYCLES + 1);

  light_t [NUM_APP-1:0] st_in;
  light_t [NUM_APP-1:0] prev_q, lamp_q;
  logic   [NUM_APP-1:0] legal, red, go, skip;

  mon_state_e   state_q, state_d;
  fault_code_e  code_q, code_d;
  logic [CW-1:0] conf_q, conf_d;
  fault_flags_t flags;
  logic         raise, clear_req, blink_clr, blink_on;

  assign st_in = {cross_st, main_st};

  for (genvar a = 0; a < NUM_APP; a++) begin : g_app
    assign legal[a] = light_legal(st_in[a]);
    assign red[a]   = (st_in[a] == LIGHT_RED);
    assign go[a]    = legal[a] && !red[a];
    assign skip[a]  = red[a] && (prev_q[a] == LIGHT_GRN);
  end

  // Conflict fires on the cycle the run of overlapping go lights would hit the limit
  always_comb begin
    flags          = '0;
    flags.illegal  = ~&legal;
    flags.conflict = (&go) && ((int'(conf_q) + 1) >= CONFLICT_CYCLES);
    flags.skip_yel = |skip;
  end

  assign raise     = |flags;
  assign clear_req = iFaultClr && (&red);

  // Sampled lights feed both the pass-through lamps and the skipped-yellow check
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      prev_q <= {NUM_APP{LIGHT_RED}};
      lamp_q <= {NUM_APP{LIGHT_RED}};
    end else begin
      prev_q <= st_in;
      lamp_q <= st_in;
    end
  end

  always_comb begin
    conf_d = conf_q;
    if (state_q == ST_FAULT && clear_req) begin
      conf_d = '0;
    end else if (|red) begin
      conf_d = '0;
    end else if (&go) begin
      if (conf_q != CW'(CONFLICT_CYCLES)) conf_d = conf_q + 1'b1;
    end
  end

  always_comb begin
    code_d = code_q;
    if (state_q == ST_NORMAL && raise) code_d = fault_prio(flags);
    else if (state_q == ST_FAULT && clear_req) code_d = FC_NONE;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      conf_q <= '0;
      code_q <= FC_NONE;
    end else begin
      conf_q <= conf_d;
      code_q <= code_d;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state_q <= ST_NORMAL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: if (raise)     state_d = ST_FAULT;
      ST_FAULT:  if (clear_req) state_d = ST_NORMAL;
      default:                  state_d = ST_NORMAL;
    endcase
  end

  // Flasher restarts in the on phase both on entry and on exit of FAULT
  assign blink_clr = (state_q == ST_NORMAL && raise) ||
                     (state_q == ST_FAULT  && clear_req);

  blink_gen #(
    .HALF (BLINK_HALF)
  ) u_blink (
    .clk_i  (iClk),
    .rst_ni (iRstN),
    .clr_i  (blink_clr),
    .en_i   (state_q == ST_FAULT),
    .on_o   (blink_on)
  );

  always_comb begin
    oFault     = 1'b0;
    oMainLamp  = lamp_q[0];
    oCrossLamp = lamp_q[1];
    if (state_q == ST_FAULT) begin
      oFault     = 1'b1;
      oMainLamp  = {blink_on, 2'b00};
      oCrossLamp = {blink_on, 2'b00};
    end
  end

  assign oFaultCode = code_q;

endmodule
